// File: rtl/uart_rx16_if.sv
// rtl/uart_rx16_if.sv - serial input and word/status outputs of the two-byte UART receiver
//
// Signals:
//    rx         serial line into the receiver, idle high
//    data       last completed 16-bit word
//    valid      one-cycle strobe when data is updated
//    frame_err  one-cycle strobe on a bad stop bit
//    sync_err   one-cycle strobe when the second byte of a word times out
//    busy       receiver is inside a frame
// Modports:
//    slave      receiver side (consumes rx, drives status and data)
//    master     host/board side (drives rx, observes status and data)
interface uart_rx16_if;
   logic        rx;
   logic [15:0] data;
   logic        valid;
   logic        frame_err;
   logic        sync_err;
   logic        busy;

   modport slave  (input  rx, output data, output valid, output frame_err, output sync_err, output busy);
   modport master (output rx, input  data, input  valid, input  frame_err, input  sync_err, input  busy);
endinterface

// File: rtl/uart_rx16.sv
// rtl/uart_rx16.sv - 8N1 UART receiver pairing consecutive bytes into 16-bit words
//
// Ports:
//    clk   system clock, single domain
//    rst   asynchronous active-high reset
//    bus   uart_rx16_if.slave: rx in; data, valid, frame_err, sync_err, busy out
// Parameters:
//    CLK_FREQ, BAUD_RATE  clock and bit rate, BAUD_TICK defaults to their ratio
//    BAUD_TICK            clock cycles per bit, at least 4
//    MSB_FIRST            1: first byte lands in data[15:8]; 0: in data[7:0]
//    TIMEOUT_BITS         bit-times allowed between byte 1 stop and byte 2 start
module uart_rx16 #(
   parameter int CLK_FREQ     = 100_000_000,
   parameter int BAUD_RATE    = 115200,
   parameter int BAUD_TICK    = CLK_FREQ / BAUD_RATE,
   parameter bit MSB_FIRST    = 1'b1,
   parameter int TIMEOUT_BITS = 32
) (
   input  logic       clk,
   input  logic       rst,
   uart_rx16_if.slave bus
);

   localparam int TO_LIMIT = BAUD_TICK * TIMEOUT_BITS;
   localparam int CW       = $clog2(TO_LIMIT + 1);

   localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_TICK / 2 - 1);
   localparam logic [CW-1:0] TICK_M1 = CW'(BAUD_TICK - 1);
   localparam logic [CW-1:0] TO_M1   = CW'(TO_LIMIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

   logic rx_m, rx_s, rx_d;

   state_t        state, state_n;
   // Bit timing and the inter-byte timeout never run together (timeout only
   // counts in IDLE), so one counter serves both.
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    bit_idx, bit_idx_n;
   logic [7:0]    shreg, shreg_n;
   logic [7:0]    hold, hold_n;
   logic          phase, phase_n;
   logic [15:0]   data_r, data_n;
   logic          valid_r, valid_n;
   logic          fe_r, fe_n;
   logic          se_r, se_n;
   logic          busy_r, busy_n;
   logic          fall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         rx_d <= 1'b1;
      end else begin
         rx_m <= bus.rx;
         rx_s <= rx_m;
         rx_d <= rx_s;
      end
   end

   assign fall = rx_d & ~rx_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         hold    <= '0;
         phase   <= 1'b0;
         data_r  <= '0;
         valid_r <= 1'b0;
         fe_r    <= 1'b0;
         se_r    <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         bit_idx <= bit_idx_n;
         shreg   <= shreg_n;
         hold    <= hold_n;
         phase   <= phase_n;
         data_r  <= data_n;
         valid_r <= valid_n;
         fe_r    <= fe_n;
         se_r    <= se_n;
         busy_r  <= busy_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      bit_idx_n = bit_idx;
      shreg_n   = shreg;
      hold_n    = hold;
      phase_n   = phase;
      data_n    = data_r;
      valid_n   = 1'b0;
      fe_n      = 1'b0;
      se_n      = 1'b0;
      busy_n    = busy_r;

      case (state)
         IDLE: begin
            // A start edge takes priority over an expiring timeout, so a
            // byte 2 arriving on the last allowed cycle is still accepted.
            if (fall) begin
               state_n = START;
               cnt_n   = '0;
               busy_n  = 1'b1;
            end else if (phase) begin
               if (cnt == TO_M1) begin
                  se_n    = 1'b1;
                  phase_n = 1'b0;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + CW'(1);
               end
            end
         end
         START: begin
            if (cnt == HALF_M1) begin
               cnt_n = '0;
               if (!rx_s) begin
                  state_n   = DATA;
                  bit_idx_n = '0;
               end else begin
                  // Line went back high before mid start bit: glitch.
                  state_n = IDLE;
                  busy_n  = 1'b0;
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         DATA: begin
            if (cnt == TICK_M1) begin
               cnt_n     = '0;
               shreg_n   = {rx_s, shreg[7:1]};
               bit_idx_n = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
                  state_n = STOP;
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         STOP: begin
            if (cnt == TICK_M1) begin
               // Leave at mid stop bit so a directly following start bit is seen.
               cnt_n  = '0;
               busy_n = 1'b0;
               if (rx_s) begin
                  state_n = IDLE;
                  if (!phase) begin
                     hold_n  = shreg;
                     phase_n = 1'b1;
                  end else begin
                     data_n  = MSB_FIRST ? {hold, shreg} : {shreg, hold};
                     valid_n = 1'b1;
                     phase_n = 1'b0;
                  end
               end else begin
                  fe_n    = 1'b1;
                  phase_n = 1'b0;
                  state_n = WAIT_HIGH;
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         WAIT_HIGH: begin
            // Hold off through a break until the line idles again.
            if (rx_s) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
            busy_n  = 1'b0;
         end
      endcase
   end

   assign bus.data      = data_r;
   assign bus.valid     = valid_r;
   assign bus.frame_err = fe_r;
   assign bus.sync_err  = se_r;
   assign bus.busy      = busy_r;

endmodule

// File: tb/tb_uart_rx16.sv
// tb/tb_uart_rx16.sv - self-checking bench for uart_rx16 (both byte orders)
module tb_uart_rx16;
   localparam int B  = 16;
   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx_line = 1'b1;

   always #5 clk = ~clk;

   uart_rx16_if bus_m ();
   uart_rx16_if bus_l ();
   assign bus_m.rx = rx_line;
   assign bus_l.rx = rx_line;

   uart_rx16 #(.BAUD_TICK(B), .TIMEOUT_BITS(TO), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(bus_m));
   uart_rx16 #(.BAUD_TICK(B), .TIMEOUT_BITS(TO), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));

   int tests = 0;
   int fails = 0;

   logic [15:0] qm[$], ql[$];
   logic [15:0] em[$], el[$];
   int fe_m = 0, se_m = 0, fe_l = 0, se_l = 0;

   always @(negedge clk) begin
      if (bus_m.valid) qm.push_back(bus_m.data);
      if (bus_l.valid) ql.push_back(bus_l.data);
      if (bus_m.frame_err) fe_m++;
      if (bus_m.sync_err) se_m++;
      if (bus_l.frame_err) fe_l++;
      if (bus_l.sync_err) se_l++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish, expected finish before 2ms");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx_line = 1'b0;
      tick(B);
      for (int i = 0; i < 8; i++) begin
         rx_line = b[i];
         tick(B);
      end
      rx_line = stop_bit;
      tick(B);
      rx_line = 1'b1;
   endtask

   // Reference rule: the first byte on the wire is the high byte when
   // MSB_FIRST=1, the low byte otherwise.
   task automatic expect_pair(input logic [7:0] b1, input logic [7:0] b2);
      em.push_back({b1, b2});
      el.push_back({b2, b1});
   endtask

   task automatic send_word(input logic [7:0] b1, input logic [7:0] b2, input int gap);
      send_byte(b1, 1'b1);
      tick(gap);
      send_byte(b2, 1'b1);
      expect_pair(b1, b2);
   endtask

   task automatic check_scen(input string tag, input int exp_fe, input int exp_se);
      check({tag, ".nvalid_m"}, qm.size(), em.size());
      check({tag, ".nvalid_l"}, ql.size(), el.size());
      for (int i = 0; i < em.size(); i++)
         if (i < qm.size()) check($sformatf("%s.data_m[%0d]", tag, i), qm[i], em[i]);
      for (int i = 0; i < el.size(); i++)
         if (i < ql.size()) check($sformatf("%s.data_l[%0d]", tag, i), ql[i], el[i]);
      check({tag, ".frame_err_m"}, fe_m, exp_fe);
      check({tag, ".sync_err_m"}, se_m, exp_se);
      check({tag, ".frame_err_l"}, fe_l, exp_fe);
      check({tag, ".sync_err_l"}, se_l, exp_se);
      check({tag, ".busy_m"}, bus_m.busy, 0);
      qm.delete(); ql.delete(); em.delete(); el.delete();
      fe_m = 0; se_m = 0; fe_l = 0; se_l = 0;
   endtask

   initial begin
      logic [15:0] w;
      int g1, g2;

      // Reset state
      tick(3);
      check("rst.data", bus_m.data, 16'h0000);
      check("rst.valid", bus_m.valid, 0);
      check("rst.frame_err", bus_m.frame_err, 0);
      check("rst.sync_err", bus_m.sync_err, 0);
      check("rst.busy", bus_m.busy, 0);
      rst = 1'b0;
      tick(10);

      // Back-to-back bytes
      send_word(8'hA5, 8'h5A, 0);
      tick(20);
      check_scen("a55a", 0, 0);

      // Two words, second all zeros, then data must hold
      send_word(8'h12, 8'h34, 0);
      tick(5);
      send_word(8'h00, 8'h00, 0);
      tick(80);
      check("zero.hold_m", bus_m.data, 16'h0000);
      check("zero.hold_l", bus_l.data, 16'h0000);
      check_scen("zero", 0, 0);

      // Short low glitch
      rx_line = 1'b0;
      tick(5);
      rx_line = 1'b1;
      tick(30);
      check("glitch.busy", bus_m.busy, 0);
      send_word(8'hBE, 8'hEF, 0);
      tick(20);
      check_scen("glitch", 0, 0);

      // Frame error then a full word
      send_byte(8'h3C, 1'b0);
      tick(40);
      send_word(8'h01, 8'h02, 0);
      tick(20);
      check_scen("frame", 1, 0);

      // Inter-byte timeout then a full word
      send_byte(8'h77, 1'b1);
      tick(120);
      send_word(8'hCA, 8'hFE, 0);
      tick(20);
      check_scen("timeout", 0, 1);

      // Reset during bit 3 of byte 2
      send_byte(8'h11, 1'b1);
      rx_line = 1'b0;
      tick(B);
      for (int i = 0; i < 3; i++) begin
         rx_line = 1'b1;
         tick(B);
      end
      rx_line = 1'b0;
      tick(B / 2);
      rst = 1'b1;
      tick(2);
      check("midrst.data", bus_m.data, 16'h0000);
      check("midrst.valid", bus_m.valid, 0);
      check("midrst.busy", bus_m.busy, 0);
      rx_line = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(20);
      send_word(8'h22, 8'h22, 0);
      tick(20);
      check_scen("midrst", 0, 0);

      // Random words with random inter-byte and inter-word gaps
      for (int k = 0; k < 6; k++) begin
         w  = 16'($urandom);
         g1 = $urandom_range(0, 20);
         g2 = $urandom_range(0, 30);
         send_word(w[15:8], w[7:0], g1);
         tick(g2);
      end
      tick(20);
      check_scen("random", 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
